rx_mac_frame_chk: RTL and testbench

//  Next-generation receive MAC. Sits between rgmii_phy_if and the rx async FIFO, clocked by the buffered RGMII rx clock.

---
 rtl/rx_mac_frame_chk_if.sv | 28 ++
 rtl/rx_mac_frame_chk.sv | 199 +++++++++++++++++++
 tb/tb_rx_mac_frame_chk.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_mac_frame_chk_if.sv
// rtl/rx_mac_frame_chk_if.sv - RGMII rx byte input, AXI-Stream byte output and stat pulses of the rx MAC
interface rx_mac_frame_chk_if;
  logic [7:0] rgmii_mac_rx_data;
  logic       rgmii_mac_rx_dv;
  logic       rgmii_mac_rx_er;
  logic       s_rx_axis_trdy;
  logic [7:0] m_rx_axis_tdata;
  logic       m_rx_axis_tvalid;
  logic       m_rx_axis_tlast;
  logic       m_rx_axis_tuser;
  logic       stat_rx_ok;
  logic       stat_rx_crc_err;
  logic       stat_rx_runt;
  logic       stat_rx_oversize;
  logic       stat_rx_abort;

  modport slave (
    input  rgmii_mac_rx_data, rgmii_mac_rx_dv, rgmii_mac_rx_er, s_rx_axis_trdy,
    output m_rx_axis_tdata, m_rx_axis_tvalid, m_rx_axis_tlast, m_rx_axis_tuser,
    output stat_rx_ok, stat_rx_crc_err, stat_rx_runt, stat_rx_oversize, stat_rx_abort
  );

  modport master (
    output rgmii_mac_rx_data, rgmii_mac_rx_dv, rgmii_mac_rx_er, s_rx_axis_trdy,
    input  m_rx_axis_tdata, m_rx_axis_tvalid, m_rx_axis_tlast, m_rx_axis_tuser,
    input  stat_rx_ok, stat_rx_crc_err, stat_rx_runt, stat_rx_oversize, stat_rx_abort
  );
endinterface

// File: rtl/rx_mac_frame_chk.sv
// rtl/rx_mac_frame_chk.sv - rx MAC framer: preamble/SFD check, byte stream out, FCS and length status
module rx_mac_frame_chk #(
  parameter int unsigned STRIP_FCS     = 1,
  parameter int unsigned MIN_PREAMBLE  = 1,
  parameter int unsigned MIN_FRAME_LEN = 64,
  parameter int unsigned MAX_FRAME_LEN = 1518,
  parameter int unsigned LEN_WIDTH     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  rx_mac_frame_chk_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  localparam logic [31:0]          CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0]          CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [2:0]           MIN_PRE     = 3'(MIN_PREAMBLE);
  localparam logic [LEN_WIDTH-1:0] MIN_LEN     = LEN_WIDTH'(MIN_FRAME_LEN);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN     = LEN_WIDTH'(MAX_FRAME_LEN);
  localparam logic [LEN_WIDTH-1:0] LEN_SAT     = LEN_WIDTH'(MAX_FRAME_LEN + 1);

  logic [7:0] din;
  logic       dv, er, trdy;
  assign din  = bus.rgmii_mac_rx_data;
  assign dv   = bus.rgmii_mac_rx_dv;
  assign er   = bus.rgmii_mac_rx_er;
  assign trdy = bus.s_rx_axis_trdy;

  state_t               state_q;
  logic [2:0]           pre_cnt_q;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [31:0]          crc_q, crc_d;
  logic [7:0]           sr_data_q [5];
  logic [4:0]           sr_frm_q, sr_ovf_q;
  logic [2:0]           drain_q;
  logic [3:0]           pend_q, status_d;
  logic                 armed_q;
  logic [7:0]           tdata_q;
  logic                 tvalid_q, tlast_q, tuser_q;
  logic [3:0]           stat_q;
  logic                 abort_q;

  always_comb begin
    crc_d = crc_q;
    for (int i = 0; i < 8; i++)
      crc_d = (crc_d[0] ^ din[i]) ? ((crc_d >> 1) ^ CRC_POLY) : (crc_d >> 1);
    len_d = (len_q == LEN_SAT) ? len_q : len_q + LEN_WIDTH'(1);
  end

  // End-of-frame verdict as {oversize, crc_err, runt, ok}, highest priority first
  always_comb begin
    status_d = 4'b0001;
    if (len_q == LEN_SAT)
      status_d = 4'b1000;
    else if (crc_q != CRC_RESIDUE)
      status_d = 4'b0100;
    else if (len_q < MIN_LEN)
      status_d = 4'b0010;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pre_cnt_q <= '0;
      len_q     <= '0;
      crc_q     <= '0;
      for (int i = 0; i < 5; i++) sr_data_q[i] <= '0;
      sr_frm_q  <= '0;
      sr_ovf_q  <= '0;
      drain_q   <= '0;
      pend_q    <= '0;
      armed_q   <= 1'b0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tuser_q   <= 1'b0;
      stat_q    <= '0;
      abort_q   <= 1'b0;
    end else begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      stat_q   <= '0;
      abort_q  <= 1'b0;
      sr_data_q[0] <= din;
      for (int i = 1; i < 5; i++) sr_data_q[i] <= sr_data_q[i-1];
      sr_frm_q <= {sr_frm_q[3:0], 1'b0};
      sr_ovf_q <= {sr_ovf_q[3:0], 1'b0};
      if (!dv) armed_q <= 1'b1;

      // FCS drain runs beside the FSM so the next preamble is parsed meanwhile
      if (drain_q != 3'd0) begin
        drain_q  <= drain_q - 3'd1;
        tvalid_q <= 1'b1;
        tdata_q  <= sr_data_q[4];
        if (drain_q == 3'd1) begin
          tlast_q <= 1'b1;
          tuser_q <= ~pend_q[0];
          stat_q  <= pend_q;
        end
      end

      case (state_q)
        IDLE: begin
          if (dv) begin
            if (armed_q && !er && din == 8'h55) begin
              state_q   <= PRE;
              pre_cnt_q <= 3'd1;
            end else begin
              state_q <= DROP;
            end
          end
        end
        PRE: begin
          if (!dv) begin
            state_q <= IDLE;
          end else if (!er && din == 8'h55) begin
            if (pre_cnt_q != 3'd7) pre_cnt_q <= pre_cnt_q + 3'd1;
          end else if (!er && din == 8'hD5 && pre_cnt_q >= MIN_PRE && trdy) begin
            state_q  <= DATA;
            len_q    <= '0;
            crc_q    <= '1;
            sr_frm_q <= '0;
            sr_ovf_q <= '0;
          end else begin
            state_q <= DROP;
            abort_q <= 1'b1;
          end
        end
        DATA: begin
          if (sr_ovf_q[4]) begin
            // The beat carrying byte MAX_FRAME_LEN+1 closes the frame
            tvalid_q  <= 1'b1;
            tdata_q   <= sr_data_q[4];
            tlast_q   <= 1'b1;
            tuser_q   <= 1'b1;
            stat_q[3] <= 1'b1;
            state_q   <= DROP;
            sr_frm_q  <= '0;
            sr_ovf_q  <= '0;
          end else if (!dv) begin
            state_q  <= IDLE;
            sr_frm_q <= '0;
            sr_ovf_q <= '0;
            if (!sr_frm_q[4]) begin
              stat_q[1] <= 1'b1;
            end else begin
              tvalid_q <= 1'b1;
              tdata_q  <= sr_data_q[4];
              if (STRIP_FCS != 0) begin
                tlast_q <= 1'b1;
                tuser_q <= ~status_d[0];
                stat_q  <= status_d;
              end else begin
                drain_q <= 3'd4;
                pend_q  <= status_d;
              end
            end
          end else if (er || !trdy) begin
            if (sr_frm_q[4]) begin
              tvalid_q <= 1'b1;
              tdata_q  <= sr_data_q[4];
              tlast_q  <= 1'b1;
              tuser_q  <= 1'b1;
            end
            if (len_q == LEN_SAT) stat_q[3] <= 1'b1;
            else                  abort_q   <= 1'b1;
            state_q  <= DROP;
            sr_frm_q <= '0;
            sr_ovf_q <= '0;
          end else begin
            crc_q    <= crc_d;
            len_q    <= len_d;
            sr_frm_q <= {sr_frm_q[3:0], 1'b1};
            sr_ovf_q <= {sr_ovf_q[3:0], len_q == MAX_LEN};
            if (sr_frm_q[4]) begin
              tvalid_q <= 1'b1;
              tdata_q  <= sr_data_q[4];
            end
          end
        end
        default: begin
          if (!dv) state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.m_rx_axis_tdata  = tdata_q;
  assign bus.m_rx_axis_tvalid = tvalid_q;
  assign bus.m_rx_axis_tlast  = tlast_q;
  assign bus.m_rx_axis_tuser  = tuser_q;
  assign bus.stat_rx_ok       = stat_q[0];
  assign bus.stat_rx_runt     = stat_q[1];
  assign bus.stat_rx_crc_err  = stat_q[2];
  assign bus.stat_rx_oversize = stat_q[3];
  assign bus.stat_rx_abort    = abort_q;
endmodule

// File: tb/tb_rx_mac_frame_chk.sv
// tb/tb_rx_mac_frame_chk.sv - directed bench for rx_mac_frame_chk with FCS stripped (dut0) and kept (dut1)
module tb_rx_mac_frame_chk;
  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_dv = 1'b0, rx_er = 1'b0, trdy = 1'b1;

  always #4 clk = ~clk;

  rx_mac_frame_chk_if if0 ();
  rx_mac_frame_chk_if if1 ();
  assign if0.rgmii_mac_rx_data = rx_data;
  assign if0.rgmii_mac_rx_dv   = rx_dv;
  assign if0.rgmii_mac_rx_er   = rx_er;
  assign if0.s_rx_axis_trdy    = trdy;
  assign if1.rgmii_mac_rx_data = rx_data;
  assign if1.rgmii_mac_rx_dv   = rx_dv;
  assign if1.rgmii_mac_rx_er   = rx_er;
  assign if1.s_rx_axis_trdy    = trdy;

  rx_mac_frame_chk #(.STRIP_FCS(1)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  rx_mac_frame_chk #(.STRIP_FCS(0)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));

  logic       tv [2], tl [2], tu [2];
  logic [7:0] td [2];
  logic [4:0] st [2];
  assign tv[0] = if0.m_rx_axis_tvalid;
  assign tl[0] = if0.m_rx_axis_tlast;
  assign tu[0] = if0.m_rx_axis_tuser;
  assign td[0] = if0.m_rx_axis_tdata;
  assign st[0] = {if0.stat_rx_abort, if0.stat_rx_oversize, if0.stat_rx_runt, if0.stat_rx_crc_err, if0.stat_rx_ok};
  assign tv[1] = if1.m_rx_axis_tvalid;
  assign tl[1] = if1.m_rx_axis_tlast;
  assign tu[1] = if1.m_rx_axis_tuser;
  assign td[1] = if1.m_rx_axis_tdata;
  assign st[1] = {if1.stat_rx_abort, if1.stat_rx_oversize, if1.stat_rx_runt, if1.stat_rx_crc_err, if1.stat_rx_ok};

  int n_tests = 0, n_fail = 0;

  // Collected beats and pulses; cnt index: 0 ok, 1 crc_err, 2 runt, 3 oversize, 4 abort
  logic [7:0] bdata [2][0:2047];
  int         nb [2], last_pos [2], last_cnt [2], c_sync [2];
  logic       last_user [2];
  int         cnt [2][5];
  logic [7:0] frm [$];
  logic [7:0] exp0 [$], exp1 [$];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (tv[k]) begin
        if (nb[k] < 2048) bdata[k][nb[k]] = td[k];
        if (tl[k]) begin
          last_pos[k]  = nb[k];
          last_cnt[k]  = last_cnt[k] + 1;
          last_user[k] = tu[k];
        end
        nb[k] = nb[k] + 1;
      end
      for (int b = 0; b < 5; b++) if (st[k][b]) cnt[k][b] = cnt[k][b] + 1;
      if (st[k] != 5'd0 && tv[k] && tl[k]) c_sync[k] = c_sync[k] + 1;
    end
  end

  task automatic clear_mon();
    for (int k = 0; k < 2; k++) begin
      nb[k] = 0; last_pos[k] = -1; last_cnt[k] = 0; c_sync[k] = 0; last_user[k] = 1'b0;
      for (int b = 0; b < 5; b++) cnt[k][b] = 0;
    end
    exp0.delete();
    exp1.delete();
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // n = byte count from dst addr through FCS; appends to the expected streams
  task automatic build(input int n, input int seed);
    logic [31:0] c;
    logic [7:0]  b;
    frm.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n - 4; i++) begin
      b = 8'((i * 37 + seed * 11 + 5) & 255);
      frm.push_back(b);
      exp0.push_back(b);
      c = crc_upd(c, b);
    end
    c = ~c;
    for (int j = 0; j < 4; j++) frm.push_back(c[8*j +: 8]);
    foreach (frm[i]) exp1.push_back(frm[i]);
  endtask

  task automatic send(input int er_at, input int trdy_at, input int gap);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      rx_dv = 1'b1; rx_er = 1'b0; trdy = 1'b1;
      rx_data = (i == 7) ? 8'hD5 : 8'h55;
    end
    for (int i = 0; i < frm.size(); i++) begin
      @(posedge clk); #1;
      rx_data = frm[i]; rx_er = (i == er_at); trdy = (i != trdy_at);
    end
    @(posedge clk); #1;
    rx_dv = 1'b0; rx_er = 1'b0; trdy = 1'b1; rx_data = 8'h00;
    repeat (gap) @(posedge clk);
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #3;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if ({tv[k], tl[k], tu[k], td[k], st[k]} !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: got %h want 0", k, {tv[k], tl[k], tu[k], td[k], st[k]});
      end
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_good();
    clear_mon();
    build(64, 1);
    send(-1, -1, 20);
    for (int k = 0; k < 2; k++) begin
      int exp_n;
      int errs;
      exp_n = (k == 0) ? 60 : 64;
      errs = 0;
      for (int i = 0; i < exp_n; i++) if (bdata[k][i] !== frm[i]) errs++;
      n_tests++;
      if (nb[k] != exp_n) begin n_fail++; $display("FAIL good_beats dut%0d: got %0d want %0d", k, nb[k], exp_n); end
      n_tests++;
      if (errs != 0) begin n_fail++; $display("FAIL good_data dut%0d: %0d bytes differ, want 0", k, errs); end
      n_tests++;
      if (last_pos[k] != exp_n - 1 || last_cnt[k] != 1) begin
        n_fail++; $display("FAIL good_tlast dut%0d: pos %0d cnt %0d want pos %0d cnt 1", k, last_pos[k], last_cnt[k], exp_n - 1);
      end
      n_tests++;
      if (last_user[k] !== 1'b0) begin n_fail++; $display("FAIL good_tuser dut%0d: got %b want 0", k, last_user[k]); end
      n_tests++;
      if (cnt[k][0] != 1 || c_sync[k] != 1 || cnt[k][1] + cnt[k][2] + cnt[k][3] + cnt[k][4] != 0) begin
        n_fail++; $display("FAIL good_stat dut%0d: ok %0d sync %0d others %0d want 1 1 0", k, cnt[k][0], c_sync[k],
                           cnt[k][1] + cnt[k][2] + cnt[k][3] + cnt[k][4]);
      end
    end
  endtask

  task automatic test_crc_err();
    clear_mon();
    build(64, 2);
    frm[10] = frm[10] ^ 8'h04;
    send(-1, -1, 20);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (nb[k] != ((k == 0) ? 60 : 64) || last_user[k] !== 1'b1) begin
        n_fail++; $display("FAIL crc_beats dut%0d: beats %0d tuser %b want %0d 1", k, nb[k], last_user[k], (k == 0) ? 60 : 64);
      end
      n_tests++;
      if (cnt[k][1] != 1 || c_sync[k] != 1 || cnt[k][0] + cnt[k][2] + cnt[k][3] + cnt[k][4] != 0) begin
        n_fail++; $display("FAIL crc_stat dut%0d: crc %0d sync %0d others %0d want 1 1 0", k, cnt[k][1], c_sync[k],
                           cnt[k][0] + cnt[k][2] + cnt[k][3] + cnt[k][4]);
      end
    end
  endtask

  task automatic test_runt();
    clear_mon();
    build(40, 3);
    send(-1, -1, 20);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (nb[k] != ((k == 0) ? 36 : 40) || last_user[k] !== 1'b1 || last_pos[k] != nb[k] - 1) begin
        n_fail++; $display("FAIL runt_beats dut%0d: beats %0d tuser %b want %0d 1", k, nb[k], last_user[k], (k == 0) ? 36 : 40);
      end
      n_tests++;
      if (cnt[k][2] != 1 || c_sync[k] != 1 || cnt[k][0] + cnt[k][1] + cnt[k][3] + cnt[k][4] != 0) begin
        n_fail++; $display("FAIL runt_stat dut%0d: runt %0d sync %0d want 1 1", k, cnt[k][2], c_sync[k]);
      end
    end
  endtask

  task automatic test_short();
    clear_mon();
    frm.delete();
    frm.push_back(8'h11); frm.push_back(8'h22); frm.push_back(8'h33);
    send(-1, -1, 20);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (nb[k] != 0 || cnt[k][2] != 1 || cnt[k][0] + cnt[k][1] + cnt[k][3] + cnt[k][4] != 0) begin
        n_fail++; $display("FAIL short_frame dut%0d: beats %0d runt %0d want 0 1", k, nb[k], cnt[k][2]);
      end
    end
  endtask

  task automatic test_oversize();
    clear_mon();
    build(1600, 5);
    send(-1, -1, 20);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (nb[k] != 1519 || last_pos[k] != 1518 || last_cnt[k] != 1 || last_user[k] !== 1'b1) begin
        n_fail++; $display("FAIL ovs_beats dut%0d: beats %0d last %0d tuser %b want 1519 1518 1", k, nb[k], last_pos[k], last_user[k]);
      end
      n_tests++;
      if (bdata[k][1518] !== frm[1518]) begin
        n_fail++; $display("FAIL ovs_lastbyte dut%0d: got %h want %h", k, bdata[k][1518], frm[1518]);
      end
      n_tests++;
      if (cnt[k][3] != 1 || c_sync[k] != 1 || cnt[k][0] + cnt[k][1] + cnt[k][2] + cnt[k][4] != 0) begin
        n_fail++; $display("FAIL ovs_stat dut%0d: oversize %0d sync %0d want 1 1", k, cnt[k][3], c_sync[k]);
      end
    end
  endtask

  task automatic test_abort();
    // er on byte 20 then trdy low on byte 30: sr[4] carries byte 15 / byte 25 as the closing beat
    for (int t = 0; t < 2; t++) begin
      int exp_n;
      clear_mon();
      build(64, 6 + t);
      exp_n = (t == 0) ? 15 : 25;
      if (t == 0) send(19, -1, 20);
      else        send(-1, 29, 20);
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (nb[k] != exp_n || last_pos[k] != exp_n - 1 || last_user[k] !== 1'b1 || bdata[k][exp_n-1] !== frm[exp_n-1]) begin
          n_fail++; $display("FAIL abort%0d_beats dut%0d: beats %0d last %0d tuser %b want %0d %0d 1", t, k, nb[k],
                             last_pos[k], last_user[k], exp_n, exp_n - 1);
        end
        n_tests++;
        if (cnt[k][4] != 1 || c_sync[k] != 1 || cnt[k][0] + cnt[k][1] + cnt[k][2] + cnt[k][3] != 0) begin
          n_fail++; $display("FAIL abort%0d_stat dut%0d: abort %0d sync %0d want 1 1", t, k, cnt[k][4], c_sync[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    build(64, 8);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      rx_dv = 1'b1; rx_er = 1'b0; trdy = 1'b1;
      rx_data = (i == 7) ? 8'hD5 : 8'h55;
    end
    for (int i = 0; i < frm.size(); i++) begin
      @(posedge clk); #1;
      rx_data = frm[i];
      if (i == 29) begin
        n_tests++;
        if (tv[0] !== 1'b1) begin n_fail++; $display("FAIL rst_pre_active: tvalid %b want 1", tv[0]); end
        #1 reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
          n_tests++;
          if ({tv[k], tl[k], tu[k], td[k], st[k]} !== 16'h0) begin
            n_fail++; $display("FAIL rst_mid_outputs dut%0d: got %h want 0", k, {tv[k], tl[k], tu[k], td[k], st[k]});
          end
        end
        clear_mon();
      end
      if (i == 32) reset_n = 1'b1;
    end
    @(posedge clk); #1;
    rx_dv = 1'b0; rx_data = 8'h00;
    repeat (20) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (nb[k] != 0 || cnt[k][0] + cnt[k][1] + cnt[k][2] + cnt[k][3] + cnt[k][4] != 0) begin
        n_fail++; $display("FAIL rst_ignored dut%0d: beats %0d pulses %0d want 0 0", k, nb[k],
                           cnt[k][0] + cnt[k][1] + cnt[k][2] + cnt[k][3] + cnt[k][4]);
      end
    end
    clear_mon();
    build(64, 9);
    send(-1, -1, 20);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (nb[k] != ((k == 0) ? 60 : 64) || cnt[k][0] != 1 || last_user[k] !== 1'b0) begin
        n_fail++; $display("FAIL rst_clean_frame dut%0d: beats %0d ok %0d tuser %b want %0d 1 0", k, nb[k], cnt[k][0],
                           last_user[k], (k == 0) ? 60 : 64);
      end
    end
  endtask

  task automatic test_back_to_back();
    int errs [2];
    clear_mon();
    build(64, 10);
    send(-1, -1, 1);
    build(70, 11);
    send(-1, -1, 20);
    errs[0] = 0;
    errs[1] = 0;
    foreach (exp0[i]) if (bdata[0][i] !== exp0[i]) errs[0]++;
    foreach (exp1[i]) if (bdata[1][i] !== exp1[i]) errs[1]++;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (nb[k] != ((k == 0) ? 126 : 134) || errs[k] != 0) begin
        n_fail++; $display("FAIL b2b_data dut%0d: beats %0d diffs %0d want %0d 0", k, nb[k], errs[k], (k == 0) ? 126 : 134);
      end
      n_tests++;
      if (cnt[k][0] != 2 || last_cnt[k] != 2 || c_sync[k] != 2 || cnt[k][1] + cnt[k][2] + cnt[k][3] + cnt[k][4] != 0) begin
        n_fail++; $display("FAIL b2b_stat dut%0d: ok %0d tlast %0d sync %0d want 2 2 2", k, cnt[k][0], last_cnt[k], c_sync[k]);
      end
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_good();
    test_crc_err();
    test_runt();
    test_short();
    test_oversize();
    test_abort();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
